ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB slave (responder) that sits between the AHB interconnect and a single-port synchronous SRAM.
- It is the counterpart of the CPU-side AHB master: it accepts single NONSEQ/SEQ transfers, drives HREADYOUT/HRESP/HRDATA, and generates SRAM strobes.
- Writes complete with zero wait states. Reads insert one wait state to cover the SRAM read latency.
- Size and alignment violations get the two-cycle AHB ERROR response.

Parameters:
- ADDR_WIDTH, 12, SRAM word-address width; SRAM depth is 2^ADDR_WIDTH 32-bit words.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-low reset
- HSEL  input  1  slave select from address decoder
- HADDR  input  32  transfer byte address
- HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HSIZE  input  3  0 byte, 1 halfword, 2 word; others illegal
- HBURST  input  3  ignored; every beat is handled independently
- HWRITE  input  1  1 write, 0 read
- HWDATA  input  32  write data, valid in the data phase
- HREADY_IN  input  1  bus-level HREADY
- HREADYOUT  output  1  slave ready
- HRESP  output  2  00 OKAY, 01 ERROR
- HRDATA  output  32  read data
- ram_ce  output  1  SRAM access enable
- ram_we  output  1  SRAM write enable
- ram_be  output  4  byte-lane write enables
- ram_addr  output  ADDR_WIDTH  SRAM word address
- ram_wdata  output  32  SRAM write data
- ram_rdata  input  32  SRAM read data, valid one clk after a read access

Behaviour:
- Reset: synchronous on rst=0 at the clk edge. State goes to IDLE and the address-phase registers clear. All outputs then take these values: HREADYOUT=1, HRESP=00, HRDATA=0, ram_ce=0, ram_we=0, ram_be=0, ram_addr=0, ram_wdata=0.
- A reset asserted mid-transfer aborts it: no RAM write occurs in the cycle after, and the pending response is dropped.
- Address-phase sample (accept): HSEL & HREADY_IN & HTRANS[1], evaluated only in IDLE, WR_DATA, RD_DATA and ERR2.
  - On accept, register HADDR[ADDR_WIDTH+1:2], HADDR[1:0], HSIZE and HWRITE.
  - Select the next state from the table below.
- IDLE/BUSY transfers, or HSEL=0: no state change, no RAM access, OKAY response.
- Illegal transfer, checked at accept:
  - HSIZE>2, or
  - HSIZE=1 with HADDR[0]=1, or
  - HSIZE=2 with HADDR[1:0]!=0.
  - Result: next state ERR1, and no RAM access for that transfer.
- States and outputs:
  - IDLE: HREADYOUT=1, HRESP=00. On a legal accepted transfer go to WR_DATA (write) or RD_WAIT (read); on an illegal one go to ERR1.
  - WR_DATA (data phase of a write, 1 cycle):
    - Outputs: HREADYOUT=1, ram_ce=1, ram_we=1, ram_addr=registered word address, ram_wdata=HWDATA (combinational pass-through), ram_be per the lane rule below.
    - Transfers are accepted in this cycle (pipelined). Next state follows the accept rule, or IDLE if nothing is accepted.
  - RD_WAIT: HREADYOUT=0, ram_ce=1, ram_we=0, ram_be=0, ram_addr=registered word address. No accept. Next state RD_DATA.
  - RD_DATA: HREADYOUT=1, HRDATA=ram_rdata (full 32-bit word; the master selects lanes). Accept allowed; next state per accept, else IDLE.
  - ERR1: HRESP=01, HREADYOUT=0, no accept. Next state ERR2.
  - ERR2: HRESP=01, HREADYOUT=1, accept allowed. Next state per accept, else IDLE.
- HRDATA=0 in every state except RD_DATA. ram_ce, ram_we and ram_be are 0 in every state except those listed above.
- Byte-lane rule (little-endian):
  - byte: ram_be = 4'b0001 << addr[1:0]
  - half: addr[1]=0 gives 4'b0011, addr[1]=1 gives 4'b1100
  - word: 4'b1111
- Latency:
  - write: 1 data-phase cycle, 0 wait states
  - read: 2 data-phase cycles, 1 wait state
  - error: 2 cycles
- HADDR bits above ADDR_WIDTH+1 are ignored; address decoding belongs to HSEL.
- Back-to-back write then read to the same address: the write reaches the SRAM in WR_DATA, before RD_WAIT issues the read, so the read returns the new data. No forwarding logic is needed.

Test Plan:
- Word write 0xDEADBEEF to 0x10, then word read 0x10. Required:
  - write: WR_DATA has ram_be=1111 and ram_addr=4
  - read: one HREADYOUT=0 cycle, then HRDATA=0xDEADBEEF with HRESP=00
- Byte write 0x000000AA to 0x13 (HSIZE=0), then half write 0x55550000 to 0x12 (HSIZE=1). Required: ram_be=1000, then ram_be=1100; HREADYOUT stays 1 throughout.
- Half read at 0x21 (misaligned), plus a transfer with HSIZE=3. Each required response:
  - ERR1 (HRESP=01, HREADYOUT=0), then ERR2 (HRESP=01, HREADYOUT=1)
  - ram_ce stays 0
- Pipelined sequence: write to 0x40 with the read of 0x40 issued in the write's data phase. Required: the read is accepted in WR_DATA and returns the just-written value two cycles later.
- HTRANS=00 and HTRANS=01 with HSEL=1, and NONSEQ with HREADY_IN=0. Required: no state change, ram_ce=0, HRESP=00.
- rst=0 asserted during RD_WAIT. Required:
  - next cycle IDLE, HREADYOUT=1, HRDATA=0, ram_ce=0
  - after release, a new write completes normally

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB responder in front of a single-port synchronous SRAM.
// Writes take one zero-wait data phase. Reads add one wait state to cover the SRAM latency.
// Illegal size/alignment combinations get the two-cycle ERROR response.
//
// Handshake: a transfer is taken when HSEL & HREADY_IN & HTRANS[1] is seen
// while the slave is able to start a new data phase. The data phase ends on the
// cycle where HREADYOUT=1. HRDATA is only meaningful in that final read cycle.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY_IN,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [31:0]           HRDATA,
    output logic                  ram_ce,
    output logic                  ram_we,
    output logic [3:0]            ram_be,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_DATA = 3'd1,
        S_RD_WAIT = 3'd2,
        S_RD_DATA = 3'd3,
        S_ERR1    = 3'd4,
        S_ERR2    = 3'd5
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            lane_q;
    logic [2:0]            size_q;
    logic                  write_q;
    logic                  accept_window;
    logic                  accept;
    logic                  illegal;
    logic [3:0]            lane_be;

    // HBURST is not needed (every beat stands alone), and the upper address bits belong to the decoder.
    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HADDR[31:ADDR_WIDTH+2]};

    // Decode the address phase: can a transfer be taken now, and is it legal?
    always_comb begin
        accept_window = (state == S_IDLE) || (state == S_WR_DATA) ||
                        (state == S_RD_DATA) || (state == S_ERR2);
        accept        = accept_window && HSEL && HREADY_IN && HTRANS[1];
        illegal       = (HSIZE > 3'd2) ||
                        ((HSIZE == 3'd1) && HADDR[0]) ||
                        ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    end

    // State register and the address-phase capture. Reset drops any pending response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= HADDR[ADDR_WIDTH+1:2];
                lane_q  <= HADDR[1:0];
                size_q  <= HSIZE;
                write_q <= HWRITE;
            end
        end
    end

    // Next-state selection. Pipelined accepts let a new transfer start in the last cycle of a data phase.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_WR_DATA, S_RD_DATA, S_ERR2: begin
                if (accept) begin
                    if (illegal)     state_nxt = S_ERR1;
                    else if (HWRITE) state_nxt = S_WR_DATA;
                    else             state_nxt = S_RD_WAIT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RD_WAIT: state_nxt = S_RD_DATA;
            S_ERR1:    state_nxt = S_ERR2;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Little-endian byte lanes for the captured size and low address bits.
    always_comb begin
        lane_be = 4'b1111;
        case (size_q)
            3'd0:    lane_be = 4'b0001 << lane_q;
            3'd1:    lane_be = lane_q[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    end

    // Bus response and SRAM strobes, all decoded from the current state.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 2'b00;
        HRDATA    = '0;
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = 4'b0000;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            S_WR_DATA: begin
                ram_ce    = 1'b1;
                ram_we    = write_q;
                ram_be    = lane_be;
                ram_addr  = addr_q;
                ram_wdata = HWDATA;
            end
            S_RD_WAIT: begin
                HREADYOUT = 1'b0;
                ram_ce    = 1'b1;
                ram_addr  = addr_q;
            end
            S_RD_DATA: begin
                HRDATA = ram_rdata;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 2'b01;
            end
            S_ERR2: begin
                HRESP = 2'b01;
            end
            default: begin
                HREADYOUT = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: directed scenarios with literal expectations,
// then randomized AHB traffic checked every cycle against a transfer-level model.
module tb_ahb_sram_slave;
    localparam int AW = 12;
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    // Clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          HSEL = 1'b0;
    logic [31:0]   HADDR = '0;
    logic [1:0]    HTRANS = '0;
    logic [2:0]    HSIZE = '0;
    logic [2:0]    HBURST = '0;
    logic          HWRITE = 1'b0;
    logic [31:0]   HWDATA = '0;
    logic          HREADY_IN = 1'b1;
    logic          HREADYOUT;
    logic [1:0]    HRESP;
    logic [31:0]   HRDATA;
    logic          ram_ce;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = '0;

    ahb_sram_slave #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY_IN (HREADY_IN),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_be    (ram_be),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Synchronous SRAM attached to the DUT strobes; read data appears one clock after the access.
    logic [31:0] sram [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) begin
                for (int i = 0; i < 4; i++)
                    if (ram_be[i]) sram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end else begin
                ram_rdata <= sram[ram_addr];
            end
        end
    end

    // Transfer-level model: each accepted transfer expands into the bus cycles of its data phase.
    localparam int PH_IDLE       = 0;
    localparam int PH_WRITE_DATA = 1;
    localparam int PH_READ_WAIT  = 2;
    localparam int PH_READ_DATA  = 3;
    localparam int PH_ERR_FIRST  = 4;
    localparam int PH_ERR_SECOND = 5;

    typedef struct {
        int            kind;
        logic [AW-1:0] waddr;
        logic [3:0]    be;
    } phase_t;

    phase_t      sched[$];
    logic [31:0] exp_q[$];
    logic [31:0] model_mem [0:DEPTH-1];

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    // Scoreboard compare
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model past the coming edge.
    task automatic check_and_advance();
        phase_t      cur;
        phase_t      ph;
        logic [31:0] exp_rd;
        logic        exp_ready;
        logic [1:0]  exp_resp;
        int          nbytes;
        logic [AW-1:0] wa;

        if (sched.size() > 0) begin
            cur = sched.pop_front();
        end else begin
            cur.kind  = PH_IDLE;
            cur.waddr = '0;
            cur.be    = '0;
        end
        exp_ready = !(cur.kind == PH_READ_WAIT || cur.kind == PH_ERR_FIRST);
        exp_resp  = (cur.kind == PH_ERR_FIRST || cur.kind == PH_ERR_SECOND) ? 2'b01 : 2'b00;
        exp_rd    = '0;
        if (cur.kind == PH_READ_DATA && exp_q.size() > 0) exp_rd = exp_q.pop_front();

        if (checking) begin
            chk("hreadyout", HREADYOUT, exp_ready);
            chk("hresp", HRESP, exp_resp);
            chk("hrdata", HRDATA, exp_rd);
            chk("ram_ce", ram_ce, cur.kind == PH_WRITE_DATA || cur.kind == PH_READ_WAIT);
            chk("ram_we", ram_we, cur.kind == PH_WRITE_DATA);
            chk("ram_be", ram_be, (cur.kind == PH_WRITE_DATA) ? cur.be : 4'b0000);
            if (cur.kind == PH_WRITE_DATA || cur.kind == PH_READ_WAIT)
                chk("ram_addr", ram_addr, cur.waddr);
            if (cur.kind == PH_IDLE) begin
                chk("ram_addr_idle", ram_addr, 0);
                chk("ram_wdata_idle", ram_wdata, 0);
            end
            if (cur.kind == PH_WRITE_DATA)
                chk("ram_wdata", ram_wdata, HWDATA);
        end

        if (cur.kind == PH_WRITE_DATA)
            for (int i = 0; i < 4; i++)
                if (cur.be[i]) model_mem[cur.waddr][8*i +: 8] = HWDATA[8*i +: 8];

        if (!rst) begin
            sched.delete();
            exp_q.delete();
            return;
        end

        if (exp_ready && HSEL && HREADY_IN && HTRANS[1]) begin
            wa = HADDR[AW+1:2];
            if (HSIZE > 3'd2 || (int'(HADDR[1:0]) % (1 << HSIZE)) != 0) begin
                ph.kind = PH_ERR_FIRST;  ph.waddr = '0; ph.be = '0; sched.push_back(ph);
                ph.kind = PH_ERR_SECOND; sched.push_back(ph);
            end else if (HWRITE) begin
                nbytes   = 1 << HSIZE;
                ph.kind  = PH_WRITE_DATA;
                ph.waddr = wa;
                ph.be    = 4'(((1 << nbytes) - 1) << HADDR[1:0]);
                sched.push_back(ph);
            end else begin
                exp_q.push_back(model_mem[wa]);
                ph.kind = PH_READ_WAIT; ph.waddr = wa; ph.be = '0; sched.push_back(ph);
                ph.kind = PH_READ_DATA; sched.push_back(ph);
            end
        end
    endtask

    // Driver: apply one cycle of inputs at the falling edge, then check and update the model.
    task automatic cycle(input logic r, input logic sel, input logic [1:0] trans,
                         input logic [31:0] addr, input logic [2:0] size, input logic wr,
                         input logic [31:0] wdata, input logic hrdy);
        @(negedge clk);
        rst       = r;
        HSEL      = sel;
        HTRANS    = trans;
        HADDR     = addr;
        HSIZE     = size;
        HWRITE    = wr;
        HWDATA    = wdata;
        HREADY_IN = hrdy;
        HBURST    = 3'($urandom_range(0, 7));
        #1;
        check_and_advance();
    endtask

    task automatic idle_cyc(input logic [31:0] wdata);
        cycle(1'b1, 1'b0, T_IDLE, 32'h0, 3'd0, 1'b0, wdata, 1'b1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]      = '0;
            model_mem[i] = '0;
        end

        // Reset
        cycle(1'b0, 1'b0, T_IDLE, 32'h0, 3'd0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, T_IDLE, 32'h0, 3'd0, 1'b0, 32'h0, 1'b1);
        checking = 1'b1;
        idle_cyc(32'h0);
        chk("rst_hreadyout", HREADYOUT, 1);
        chk("rst_hresp", HRESP, 0);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_ram_ce", ram_ce, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_be", ram_be, 0);
        chk("rst_ram_addr", ram_addr, 0);

        // Word write 0xDEADBEEF to 0x10, then word read back
        cycle(1'b1, 1'b1, T_NONSEQ, 32'h10, 3'd2, 1'b1, 32'h0, 1'b1);
        idle_cyc(32'hDEADBEEF);
        chk("t1_wr_be", ram_be, 4'b1111);
        chk("t1_wr_addr", ram_addr, 4);
        chk("t1_wr_we", ram_we, 1);
        cycle(1'b1, 1'b1, T_NONSEQ, 32'h10, 3'd2, 1'b0, 32'h0, 1'b1);
        idle_cyc(32'h0);
        chk("t1_rd_wait", HREADYOUT, 0);
        idle_cyc(32'h0);
        chk("t1_rd_data", HRDATA, 32'hDEADBEEF);
        chk("t1_rd_resp", HRESP, 0);
        chk("t1_rd_ready", HREADYOUT, 1);

        // Byte write to 0x13, then pipelined half write to 0x12
        cycle(1'b1, 1'b1, T_NONSEQ, 32'h13, 3'd0, 1'b1, 32'h0, 1'b1);
        chk("t2_addr_ready", HREADYOUT, 1);
        cycle(1'b1, 1'b1, T_NONSEQ, 32'h12, 3'd1, 1'b1, 32'h000000AA, 1'b1);
        chk("t2_byte_be", ram_be, 4'b1000);
        chk("t2_byte_ready", HREADYOUT, 1);
        idle_cyc(32'h55550000);
        chk("t2_half_be", ram_be, 4'b1100);
        chk("t2_half_ready", HREADYOUT, 1);

        // Misaligned half read at 0x21, then HSIZE=3 accepted in the second error cycle
        cycle(1'b1, 1'b1, T_NONSEQ, 32'h21, 3'd1, 1'b0, 32'h0, 1'b1);
        idle_cyc(32'h0);
        chk("t3a_err1_resp", HRESP, 2'b01);
        chk("t3a_err1_ready", HREADYOUT, 0);
        chk("t3a_err1_ce", ram_ce, 0);
        cycle(1'b1, 1'b1, T_NONSEQ, 32'h30, 3'd3, 1'b0, 32'h0, 1'b1);
        chk("t3a_err2_resp", HRESP, 2'b01);
        chk("t3a_err2_ready", HREADYOUT, 1);
        chk("t3a_err2_ce", ram_ce, 0);
        idle_cyc(32'h0);
        chk("t3b_err1_resp", HRESP, 2'b01);
        chk("t3b_err1_ready", HREADYOUT, 0);
        chk("t3b_err1_ce", ram_ce, 0);
        idle_cyc(32'h0);
        chk("t3b_err2_resp", HRESP, 2'b01);
        chk("t3b_err2_ready", HREADYOUT, 1);
        chk("t3b_err2_ce", ram_ce, 0);
        idle_cyc(32'h0);

        // Write 0x40 with the read of 0x40 issued in the write data phase
        cycle(1'b1, 1'b1, T_NONSEQ, 32'h40, 3'd2, 1'b1, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, T_NONSEQ, 32'h40, 3'd2, 1'b0, 32'h12345678, 1'b1);
        chk("t4_wr_addr", ram_addr, 32'h10);
        chk("t4_wr_we", ram_we, 1);
        idle_cyc(32'h0);
        chk("t4_rd_wait_ready", HREADYOUT, 0);
        chk("t4_rd_wait_ce", ram_ce, 1);
        idle_cyc(32'h0);
        chk("t4_rd_data", HRDATA, 32'h12345678);

        // IDLE, BUSY with HSEL=1, and NONSEQ while HREADY_IN=0 are all ignored
        cycle(1'b1, 1'b1, T_IDLE, 32'h10, 3'd2, 1'b1, 32'h0, 1'b1);
        idle_cyc(32'h0);
        chk("t5_idle_ce", ram_ce, 0);
        chk("t5_idle_resp", HRESP, 0);
        cycle(1'b1, 1'b1, T_BUSY, 32'h10, 3'd2, 1'b1, 32'h0, 1'b1);
        idle_cyc(32'h0);
        chk("t5_busy_ce", ram_ce, 0);
        chk("t5_busy_ready", HREADYOUT, 1);
        cycle(1'b1, 1'b1, T_NONSEQ, 32'h10, 3'd2, 1'b1, 32'h0, 1'b0);
        idle_cyc(32'h0);
        chk("t5_nordy_ce", ram_ce, 0);
        chk("t5_nordy_we", ram_we, 0);
        chk("t5_nordy_resp", HRESP, 0);

        // Reset asserted while the read waits, then a fresh write/read
        cycle(1'b1, 1'b1, T_NONSEQ, 32'h40, 3'd2, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, T_IDLE, 32'h0, 3'd0, 1'b0, 32'h0, 1'b1);
        chk("t6_wait_ready", HREADYOUT, 0);
        idle_cyc(32'h0);
        chk("t6_after_ready", HREADYOUT, 1);
        chk("t6_after_hrdata", HRDATA, 0);
        chk("t6_after_ce", ram_ce, 0);
        cycle(1'b1, 1'b1, T_NONSEQ, 32'h44, 3'd2, 1'b1, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, T_NONSEQ, 32'h44, 3'd2, 1'b0, 32'hCAFEF00D, 1'b1);
        chk("t6_wr_addr", ram_addr, 32'h11);
        chk("t6_wr_we", ram_we, 1);
        idle_cyc(32'h0);
        idle_cyc(32'h0);
        chk("t6_rd_data", HRDATA, 32'hCAFEF00D);

        // Randomized traffic; upper address bits are random to show they are ignored
        for (int n = 0; n < 3000; n++) begin
            logic          r;
            logic          sel;
            logic [2:0]    sz;
            logic [31:0]   a;
            r   = ($urandom_range(0, 199) != 0);
            sel = ($urandom_range(0, 9) != 0);
            sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a   = ($urandom() & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
            cycle(r, sel, 2'($urandom_range(0, 3)), a, sz, 1'($urandom_range(0, 1)),
                  $urandom(), ($urandom_range(0, 9) != 0));
        end
        idle_cyc(32'h0);
        idle_cyc(32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
